// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor: 2-bit saturating-counter predictor (bimodal or gshare)    |
// | with a one-entry-per-cycle table initialisation sweep. Rev 1.0              |
// +----------------------------------------------------------------------------+
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int GHR_BITS = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic                                     ready,
  input  logic [31:0]                              IF_pc,
  output logic [1:0]                               IF_branch_prediction,
  output logic                                     IF_predict_taken,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] IF_ghr,
  input  logic                                     EX_Branch,
  input  logic [31:0]                              EX_pc,
  input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] EX_ghr,
  input  logic [1:0]                               EX_branch_prediction,
  input  logic                                     branch_taken,
  output logic [1:0]                               prediction_status,
  output logic                                     mispredict,
  output logic [31:0]                              branch_count,
  output logic [31:0]                              mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [IDX-1:0] c_last_idx = IDX'(ENTRIES - 1);
  localparam logic [IDX-1:0] c_idx_one  = IDX'(1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDX-1:0] r_sweep_idx;
  logic [IDX-1:0] w_sweep_idx_next;
  logic [1:0]     r_table [ENTRIES];
  logic [IDX-1:0] w_if_idx;
  logic [IDX-1:0] w_ex_idx;
  logic [GW-1:0]  w_ghr;
  logic           w_accept;
  logic           w_mispredict;
  logic [1:0]     w_new_ctr;
  logic           w_tab_we;
  logic [IDX-1:0] w_tab_waddr;
  logic [1:0]     w_tab_wdata;
  logic [31:0]    r_branch_count;
  logic [31:0]    r_mispredict_count;
  logic           w_unused_bits;

  assign ready    = (r_state == RUN);
  assign w_accept = EX_Branch & ready;

  generate
    if (GHR_BITS == 0) begin : g_bimodal
      assign w_if_idx = IF_pc[IDX+1:2];
      assign w_ex_idx = EX_pc[IDX+1:2];
      assign w_ghr    = '0;
    end else begin : g_gshare
      logic [GW-1:0] r_ghr;
      logic [GW-1:0] w_ghr_next;

      // Update index uses the fetch-time history carried down the pipe.
      assign w_if_idx = IF_pc[IDX+1:2] ^ IDX'(r_ghr);
      assign w_ex_idx = EX_pc[IDX+1:2] ^ IDX'(EX_ghr);
      assign w_ghr    = r_ghr;

      if (GHR_BITS == 1) begin : g_ghr_one
        assign w_ghr_next = branch_taken;
      end else begin : g_ghr_shift
        assign w_ghr_next = {EX_ghr[GHR_BITS-2:0], branch_taken};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ghr <= '0;
        end else if (w_accept) begin
          r_ghr <= w_ghr_next;
        end
      end
    end
  endgenerate

  assign IF_ghr               = w_ghr;
  assign IF_branch_prediction = ready ? r_table[w_if_idx] : 2'b01;
  assign IF_predict_taken     = IF_branch_prediction[1];

  always_comb begin
    w_new_ctr = EX_branch_prediction;
    if (branch_taken) begin
      if (EX_branch_prediction != 2'b11) begin
        w_new_ctr = EX_branch_prediction + 2'b01;
      end
    end else begin
      if (EX_branch_prediction != 2'b00) begin
        w_new_ctr = EX_branch_prediction - 2'b01;
      end
    end
  end

  // Status bit 1 = prediction correct, bit 0 = predicted direction.
  assign w_mispredict      = w_accept & (EX_branch_prediction[1] ^ branch_taken);
  assign mispredict        = w_mispredict;
  assign prediction_status = w_accept ?
                             {~(EX_branch_prediction[1] ^ branch_taken), EX_branch_prediction[1]} :
                             2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_idx <= w_sweep_idx_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sweep_idx_next = r_sweep_idx;
    w_tab_we         = 1'b0;
    w_tab_waddr      = w_ex_idx;
    w_tab_wdata      = w_new_ctr;
    case (r_state)
      INIT: begin
        w_tab_we         = 1'b1;
        w_tab_waddr      = r_sweep_idx;
        w_tab_wdata      = 2'b01;
        w_sweep_idx_next = r_sweep_idx + c_idx_one;
        if (r_sweep_idx == c_last_idx) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_tab_we = EX_Branch;
      end
      default: begin
        w_state_next = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tab_we && !rst) begin
      r_table[w_tab_waddr] <= w_tab_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_accept) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  assign w_unused_bits = ^{IF_pc[31:IDX+2], IF_pc[1:0], EX_pc[31:IDX+2], EX_pc[1:0],
                           EX_ghr, EX_branch_prediction[0]};

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, meaning pattern-table depth; it SHALL be a power of two and at least 4.
REQ-002 SHALL have parameter GHR_BITS, default 0, meaning global-history length; 0 selects bimodal mode, and 1..log2(ENTRIES) selects gshare mode.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ready, output, 1 bit: table initialisation is complete.
REQ-006 SHALL have port IF_pc, input, 32 bits: fetch PC.
REQ-007 SHALL have port IF_branch_prediction, output, 2 bits: counter value at the fetch index, combinational.
REQ-008 SHALL have port IF_predict_taken, output, 1 bit: equal to IF_branch_prediction[1].
REQ-009 SHALL have port IF_ghr, output, max(GHR_BITS,1) bits: current history snapshot, for the pipeline to carry to EX.
REQ-010 SHALL have port EX_Branch, input, 1 bit: a resolved conditional branch is present in EX this cycle.
REQ-011 SHALL have ports EX_pc (input, 32 bits), EX_ghr (input, max(GHR_BITS,1) bits) and EX_branch_prediction (input, 2 bits): the fetch-time PC, history and counter for the EX branch.
REQ-012 SHALL have port branch_taken, input, 1 bit: resolved branch outcome.
REQ-013 SHALL have port prediction_status, output, 2 bits, with encoding 0 = predicted NT / actual T, 1 = predicted T / actual NT, 2 = predicted NT / actual NT, 3 = predicted T / actual T.
REQ-014 SHALL have port mispredict, output, 1 bit: EX_Branch & (prediction_status is 0 or 1).
REQ-015 SHALL have ports branch_count and mispredict_count, both output, 32 bits: statistics counters.

Function
REQ-016 Fetch index SHALL be IF_pc[log2(ENTRIES)+1:2] XOR zero-extended GHR in gshare mode, and the PC bits alone in bimodal mode.
REQ-017 Update index SHALL be computed identically from EX_pc and EX_ghr, never from the live GHR.
REQ-018 Each entry SHALL be a 2-bit saturating counter:
- taken increments and saturates at 3;
- not-taken decrements and saturates at 0.
REQ-019 The update SHALL be written at the clock edge ending the cycle in which EX_Branch=1 and ready=1.
REQ-020 The new counter value SHALL be derived from EX_branch_prediction, not from a re-read of the table.
REQ-021 When fetch and update address the same entry in the same cycle, IF_branch_prediction SHALL return the pre-update value (no bypass).
REQ-022 In gshare mode, on each accepted update, GHR SHALL load {EX_ghr[GHR_BITS-2:0], branch_taken}; for GHR_BITS=1 it SHALL load branch_taken.
REQ-023 GHR SHALL be non-speculative, and IF_ghr SHALL read constant 0 in bimodal mode.
REQ-024 prediction_status and mispredict SHALL be combinational from EX_branch_prediction[1] and branch_taken.
REQ-025 prediction_status SHALL be 0 and mispredict SHALL be 0 whenever EX_Branch=0 or ready=0.
REQ-026 branch_count SHALL increment by 1 per accepted update.
REQ-027 mispredict_count SHALL increment by 1 per accepted update with mispredict=1.
REQ-028 Both statistics counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 Init FSM states SHALL be INIT and RUN.
REQ-030 In INIT, the FSM SHALL write 2'b01 to one entry per cycle, for indices 0..ENTRIES-1 in order.
REQ-031 After index ENTRIES-1 is written, the FSM SHALL enter RUN; ready SHALL be 1 only in RUN.
REQ-032 While ready=0, IF_branch_prediction SHALL read 2'b01, and EX updates SHALL be ignored: no table write, no GHR change, no count.

Reset
REQ-033 rst=1 at a clock edge SHALL set state=INIT, sweep index=0, GHR=0, branch_count=0, mispredict_count=0 and ready=0.
REQ-034 rst asserted mid-sweep or during RUN SHALL restart the sweep from index 0.
REQ-035 Initialisation SHALL take exactly ENTRIES cycles after rst deasserts; ready SHALL rise on the following edge.
REQ-036 No table contents SHALL be relied on before the sweep completes.

Verification
REQ-037 Scenario: ENTRIES=64; release rst; count cycles -> ready=1 after exactly 64 cycles; every PC reads 2'b01.
REQ-038 Scenario: bimodal mode; the same PC is resolved taken 4 times, feeding back IF_branch_prediction each time -> counter goes 1,2,3,3; branch_count=4; mispredict_count=1.
REQ-039 Scenario: bimodal mode; counter=3, resolved not-taken with EX_branch_prediction=3 -> prediction_status=1, mispredict=1, counter=2.
REQ-040 Scenario: GHR_BITS=4, EX_ghr=4'b1011, taken -> GHR=4'b0111; fetch of PC 0x40 indexes entry 16 XOR 7 = 23.
REQ-041 Scenario: same-cycle fetch and update to entry 5 (counter 1, taken) -> IF reads 1 that cycle and 2 the next.
REQ-042 Scenario: rst pulsed at sweep index 30, with EX_Branch held high during INIT -> sweep restarts at 0; counters stay 0; ready rises 64 cycles later.
